// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and saturating stall/drop debug counters.
module pipe_skid_stage #(
    parameter int                DATA_W     = 96,
    parameter int                CTRL_W     = 16,
    parameter logic [CTRL_W-1:0] FLUSH_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stat_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        drop_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;
    // a MAIN entry leaving downstream on the flush edge is delivered, not dropped
    assign drop_inc  = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            main_ctrl  <= FLUSH_CTRL;
            skid_ctrl  <= FLUSH_CTRL;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= FLUSH_CTRL;
            skid_ctrl  <= FLUSH_CTRL;
        end else begin
            case ({main_valid, skid_valid})
                2'b00: begin
                    if (in_xfer) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                    end
                end
                2'b10: begin
                    if (in_xfer && out_xfer) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (in_xfer) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                        skid_ctrl  <= in_ctrl;
                    end else if (out_xfer) begin
                        main_valid <= 1'b0;
                        main_ctrl  <= FLUSH_CTRL;
                    end
                end
                2'b11: begin
                    if (out_xfer) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        skid_valid <= 1'b0;
                        skid_ctrl  <= FLUSH_CTRL;
                    end
                end
                default: begin
                    skid_valid <= 1'b0;
                    skid_ctrl  <= FLUSH_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (main_valid && !out_ready) begin
                stall_cnt <= sat_add(stall_cnt, 2'd1);
            end
            if (flush) begin
                drop_cnt <= sat_add(drop_cnt, drop_inc);
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: hand-written vector table and corner sequences plus
// randomized traffic checked against a queue-based reference model.
module tb_pipe_skid_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         stat_clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [95:0]  in_data = '0;
    logic [15:0]  in_ctrl = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [95:0]  out_data;
    logic [15:0]  out_ctrl;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cnt;
    logic [15:0]  drop_cnt;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [95:0]  s_out_data;
    logic [15:0]  s_out_ctrl;
    logic [1:0]   s_occupancy;
    logic [3:0]   s_stall_cnt;
    logic [3:0]   s_drop_cnt;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    pipe_skid_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .flush(flush), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] d;
        logic [15:0] c;
    } ent_t;

    typedef struct {
        logic       iv;
        logic [7:0] dat;
        logic       ordy;
        logic       fl;
        logic       e_ov;
        logic [7:0] e_dat;
        logic [1:0] e_occ;
        logic       e_ir;
        int         e_stall;
        int         e_drop;
    } vec_t;

    ent_t        q[$];
    int          m_stall = 0;
    int          m_drop = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [95:0] seen[$];
    int          seen_cyc[$];
    logic [1:0]  max_occ;
    vec_t        tbl[18];

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("in_ready", 128'(in_ready), 128'(q.size() < 2));
        check("out_valid", 128'(out_valid), 128'(q.size() > 0));
        check("occupancy", 128'(occupancy), 128'(q.size()));
        if (q.size() > 0) begin
            check("out_data", 128'(out_data), 128'(q[0].d));
            check("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
        end else begin
            check("out_ctrl_idle", 128'(out_ctrl), 128'(16'h0));
        end
        check("stall_cnt", 128'(stall_cnt), 128'(sat(m_stall, 65535)));
        check("drop_cnt", 128'(drop_cnt), 128'(sat(m_drop, 65535)));
        check("s_occupancy", 128'(s_occupancy), 128'(q.size()));
        check("s_stall_cnt", 128'(s_stall_cnt), 128'(sat(m_stall, 15)));
        check("s_drop_cnt", 128'(s_drop_cnt), 128'(sat(m_drop, 15)));
    endtask

    // one clock: drive, check pre-edge state at negedge, advance model at posedge
    task automatic step(input logic iv, input logic [95:0] id, input logic [15:0] ic,
                        input logic ordy, input logic fl, input logic sc);
        bit ir;
        bit ov;
        in_valid = iv; in_data = id; in_ctrl = ic;
        out_ready = ordy; flush = fl; stat_clr = sc;
        @(negedge clk);
        check_state();
        if (out_valid && out_ready) begin
            seen.push_back(out_data);
            seen_cyc.push_back(cyc);
        end
        if (occupancy > max_occ) max_occ = occupancy;
        @(posedge clk);
        ir = (q.size() < 2);
        ov = (q.size() > 0);
        if (ov && !ordy) m_stall++;
        if (fl) begin
            m_drop += q.size() - ((ov && ordy) ? 1 : 0);
            q.delete();
        end else begin
            if (ov && ordy) void'(q.pop_front());
            if (iv && ir) q.push_back('{id, ic});
        end
        if (sc) begin
            m_stall = 0;
            m_drop = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        check({tag, "_occupancy"}, 128'(occupancy), 128'(2'd0));
        check({tag, "_out_ctrl"}, 128'(out_ctrl), 128'(16'h0));
        check({tag, "_out_data"}, 128'(out_data), 128'(96'h0));
        check({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(16'h0));
        check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(16'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1, 0, 0};
        tbl[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0, 2, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b1, 2, 0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 2, 0};
        tbl[5]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA4, 2'd1, 1'b1, 2, 0};
        tbl[6]  = '{1'b1, 8'hB5, 1'b0, 1'b0, 1'b1, 8'hA4, 2'd2, 1'b0, 3, 0};
        tbl[7]  = '{1'b1, 8'hC6, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[9]  = '{1'b1, 8'hD7, 1'b0, 1'b0, 1'b1, 8'hD7, 2'd1, 1'b1, 4, 2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[11] = '{1'b1, 8'hE8, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[13] = '{1'b1, 8'hF9, 1'b1, 1'b0, 1'b1, 8'hF9, 2'd1, 1'b1, 4, 2};
        tbl[14] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'hAA, 2'd1, 1'b1, 4, 2};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4, 2};
        tbl[16] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 8'hBB, 2'd1, 1'b1, 4, 2};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 5, 3};

        // reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // streaming 1..8 with out_ready=1
        seen.delete();
        seen_cyc.delete();
        max_occ = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 96'(i), 16'(i), 1'b1, 1'b0, 1'b0);
            if (i == 1) begin
                check("stream_first_valid", 128'(out_valid), 128'(1'b1));
                check("stream_first_data", 128'(out_data), 128'(96'h1));
            end
        end
        repeat (2) step(1'b0, 96'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("stream_count", 128'(seen.size()), 128'(8));
        if (seen.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check("stream_order", 128'(seen[i]), 128'(i + 1));
            check("stream_consecutive", 128'(seen_cyc[7] - seen_cyc[0]), 128'(7));
        end
        check("stream_max_occ", 128'(max_occ), 128'(2'd1));
        check("stream_stall", 128'(stall_cnt), 128'(16'h0));

        // backpressure / flush vector table
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].iv, {88'h0, tbl[i].dat}, {8'hC0, tbl[i].dat},
                 tbl[i].ordy, tbl[i].fl, 1'b0);
            check($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            check($sformatf("tbl%0d_occupancy", i), 128'(occupancy), 128'(tbl[i].e_occ));
            check($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
            check($sformatf("tbl%0d_stall", i), 128'(stall_cnt), 128'(tbl[i].e_stall));
            check($sformatf("tbl%0d_drop", i), 128'(drop_cnt), 128'(tbl[i].e_drop));
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d_out_data", i), 128'(out_data), 128'({88'h0, tbl[i].e_dat}));
                check($sformatf("tbl%0d_out_ctrl", i), 128'(out_ctrl), 128'({8'hC0, tbl[i].e_dat}));
            end else begin
                check($sformatf("tbl%0d_out_ctrl", i), 128'(out_ctrl), 128'(16'h0));
            end
        end

        // saturation on the 4-bit counters, then clear while still stalled
        step(1'b1, 96'h55, 16'h55, 1'b0, 1'b0, 1'b1);
        check("sat_clr_start", 128'(stall_cnt), 128'(16'h0));
        repeat (20) step(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("sat_small_stall", 128'(s_stall_cnt), 128'(4'd15));
        check("sat_wide_stall", 128'(stall_cnt), 128'(16'd20));
        check("sat_hold_data", 128'(out_data), 128'(96'h55));
        step(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("clr_small_stall", 128'(s_stall_cnt), 128'(4'd0));
        check("clr_wide_stall", 128'(stall_cnt), 128'(16'd0));
        step(1'b0, 96'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("clr_next_stall", 128'(s_stall_cnt), 128'(4'd1));
        step(1'b0, 96'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        // randomized traffic against the queue model
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 {$urandom(), $urandom(), $urandom()},
                 16'($urandom()),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 63) == 0));
        end

        // async reset while FULL, asserted between edges
        step(1'b0, 96'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 96'h61, 16'h61, 1'b0, 1'b0, 1'b0);
        step(1'b1, 96'h62, 16'h62, 1'b0, 1'b0, 1'b0);
        check("pre_reset_occ", 128'(occupancy), 128'(2'd2));
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        #1;
        rst = 1'b1;
        q.delete();
        m_stall = 0;
        m_drop = 0;
        step(1'b1, 96'h77, 16'h77, 1'b0, 1'b0, 1'b0);
        check("post_reset_valid", 128'(out_valid), 128'(1'b1));
        check("post_reset_data", 128'(out_data), 128'(96'h77));
        step(1'b0, 96'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 96'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
